// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon-AEAD128 control sequencer.
package ascon_pack;

  localparam int PAD_AW = 4;

  localparam logic [3:0] ROUNDS_A = 4'd12;
  localparam logic [3:0] ROUNDS_B = 4'd8;

  typedef enum logic [2:0] {
    OP_INIT_LOAD = 3'd0,
    OP_KEY_TAIL  = 3'd1,
    OP_DOMSEP    = 3'd2,
    OP_KEY_FINAL = 3'd3,
    OP_TAG_OUT   = 3'd4
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD       = 4'd1,
    ST_INIT_PERM  = 4'd2,
    ST_KEY_TAIL   = 4'd3,
    ST_AD_BLK     = 4'd4,
    ST_AD_PERM    = 4'd5,
    ST_DOMSEP     = 4'd6,
    ST_DI_BLK     = 4'd7,
    ST_DI_PERM    = 4'd8,
    ST_KEY_FINAL  = 4'd9,
    ST_FINAL_PERM = 4'd10,
    ST_TAG        = 4'd11
  } sched_state_e;

  function automatic logic is_perm(sched_state_e s);
    return (s == ST_INIT_PERM) || (s == ST_AD_PERM) ||
           (s == ST_DI_PERM) || (s == ST_FINAL_PERM);
  endfunction

endpackage

// File: rtl/ascon_size_decoder.sv
// Splits AD/DI byte sizes into full-block counts, pad byte indices and the AD-present flag.
module ascon_size_decoder
  import ascon_pack::*;
#(
  parameter int SIZE_WIDTH = 16,
  parameter int BLOCK_AW   = 12
) (
  input  logic [SIZE_WIDTH-1:0] ad_size,
  input  logic [SIZE_WIDTH-1:0] di_size,
  output logic [BLOCK_AW-1:0]   ad_blocks,
  output logic [BLOCK_AW-1:0]   di_blocks,
  output logic [PAD_AW-1:0]     ad_pad,
  output logic [PAD_AW-1:0]     di_pad,
  output logic                  ad_en
);

  assign ad_blocks = ad_size[PAD_AW +: BLOCK_AW];
  assign di_blocks = di_size[PAD_AW +: BLOCK_AW];
  assign ad_pad    = ad_size[PAD_AW-1:0];
  assign di_pad    = di_size[PAD_AW-1:0];
  assign ad_en     = |ad_size;

endmodule

// File: rtl/ascon_aead_sequencer.sv
// Ascon-AEAD128 control FSM: init, AD absorb, domain separation, DI, finalise, tag.
// Optional ASCON_SCHED_ABORT_EN adds abort_i, which returns the FSM to IDLE from any state.
module ascon_aead_sequencer
  import ascon_pack::*;
#(
  parameter int SIZE_WIDTH = 16,
  parameter int BLOCK_AW   = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [SIZE_WIDTH-1:0] ad_size_i,
  input  logic [SIZE_WIDTH-1:0] di_size_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  op_valid_o,
  output op_e                   op_o,
  output logic                  perm_start_o,
  output logic [3:0]            perm_rounds_o,
  input  logic                  perm_done_i,
  output logic                  blk_valid_o,
  input  logic                  blk_ready_i,
  output logic                  blk_sel_o,
  output logic                  blk_last_o,
  output logic [PAD_AW-1:0]     blk_pad_idx_o,
`ifdef ASCON_SCHED_ABORT_EN
  input  logic                  abort_i,
`endif
  output sched_state_e          state_o
);

  // Handshake: a block moves on any cycle where blk_valid_o && blk_ready_i; the
  // sideband (sel/last/pad) only changes on such a transfer, so it is stable while valid waits.

  sched_state_e          state_q, state_d;
  logic                  entered_q;
  logic                  last_q;
  logic [SIZE_WIDTH-1:0] ad_size_q, di_size_q;
  logic [BLOCK_AW-1:0]   ad_cnt_q, di_cnt_q;
  logic [BLOCK_AW-1:0]   ad_blocks, di_blocks;
  logic [PAD_AW-1:0]     ad_pad, di_pad;
  logic                  ad_en;
  logic                  abort;
  logic                  perm_go;
  logic                  xfer;
  logic                  start_ok;

`ifdef ASCON_SCHED_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  ascon_size_decoder #(
    .SIZE_WIDTH(SIZE_WIDTH),
    .BLOCK_AW  (BLOCK_AW)
  ) u_size_decoder (
    .ad_size  (ad_size_q),
    .di_size  (di_size_q),
    .ad_blocks(ad_blocks),
    .di_blocks(di_blocks),
    .ad_pad   (ad_pad),
    .di_pad   (di_pad),
    .ad_en    (ad_en)
  );

  // entered_q marks the first cycle of a state: it starts the permutation and masks perm_done_i.
  assign perm_go  = perm_done_i && !entered_q;
  assign xfer     = blk_valid_o && blk_ready_i;
  assign start_ok = (state_q == ST_IDLE) && start_i && !abort;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = (state_q == ST_TAG);
  assign state_o  = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      entered_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      entered_q <= (state_d != state_q);
    end
  end

  always_comb begin
    state_d       = state_q;
    op_valid_o    = 1'b0;
    op_o          = OP_INIT_LOAD;
    perm_start_o  = 1'b0;
    perm_rounds_o = 4'd0;
    blk_valid_o   = 1'b0;
    blk_sel_o     = 1'b0;
    blk_last_o    = 1'b0;
    blk_pad_idx_o = '0;
    if (is_perm(state_q)) perm_start_o = entered_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_LOAD;
      ST_LOAD: begin
        op_valid_o = 1'b1;
        op_o       = OP_INIT_LOAD;
        state_d    = ST_INIT_PERM;
      end
      ST_INIT_PERM: begin
        if (entered_q) perm_rounds_o = ROUNDS_A;
        if (perm_go) state_d = ST_KEY_TAIL;
      end
      ST_KEY_TAIL: begin
        op_valid_o = 1'b1;
        op_o       = OP_KEY_TAIL;
        state_d    = ad_en ? ST_AD_BLK : ST_DOMSEP;
      end
      ST_AD_BLK: begin
        blk_valid_o = 1'b1;
        blk_sel_o   = 1'b0;
        blk_last_o  = (ad_cnt_q == '0);
        if (blk_last_o) blk_pad_idx_o = ad_pad;
        if (blk_ready_i) state_d = ST_AD_PERM;
      end
      ST_AD_PERM: begin
        if (entered_q) perm_rounds_o = ROUNDS_B;
        if (perm_go) state_d = last_q ? ST_DOMSEP : ST_AD_BLK;
      end
      ST_DOMSEP: begin
        op_valid_o = 1'b1;
        op_o       = OP_DOMSEP;
        state_d    = ST_DI_BLK;
      end
      ST_DI_BLK: begin
        blk_valid_o = 1'b1;
        blk_sel_o   = 1'b1;
        blk_last_o  = (di_cnt_q == '0);
        if (blk_last_o) blk_pad_idx_o = di_pad;
        // The final DI block goes straight to finalisation without a permutation.
        if (blk_ready_i) state_d = blk_last_o ? ST_KEY_FINAL : ST_DI_PERM;
      end
      ST_DI_PERM: begin
        if (entered_q) perm_rounds_o = ROUNDS_B;
        if (perm_go) state_d = ST_DI_BLK;
      end
      ST_KEY_FINAL: begin
        op_valid_o = 1'b1;
        op_o       = OP_KEY_FINAL;
        state_d    = ST_FINAL_PERM;
      end
      ST_FINAL_PERM: begin
        if (entered_q) perm_rounds_o = ROUNDS_A;
        if (perm_go) state_d = ST_TAG;
      end
      ST_TAG: begin
        op_valid_o = 1'b1;
        op_o       = OP_TAG_OUT;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Counters load in LOAD from the sizes latched at start; they only step on non-last
  // transfers, so an all-ones count reaches zero exactly at the final block.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ad_size_q <= '0;
      di_size_q <= '0;
      ad_cnt_q  <= '0;
      di_cnt_q  <= '0;
      last_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        ad_size_q <= ad_size_i;
        di_size_q <= di_size_i;
      end
      if (state_q == ST_LOAD) begin
        ad_cnt_q <= ad_blocks;
        di_cnt_q <= di_blocks;
      end else if (xfer && !blk_last_o) begin
        if (blk_sel_o) di_cnt_q <= di_cnt_q - BLOCK_AW'(1);
        else           ad_cnt_q <= ad_cnt_q - BLOCK_AW'(1);
      end
      if (xfer) last_q <= blk_last_o;
    end
  end

endmodule

// File: tb/tb_ascon_aead_sequencer.sv
// Self-checking bench for ascon_aead_sequencer: scenario tasks with an expected-value queue scoreboard.
module tb_ascon_aead_sequencer;
  import ascon_pack::*;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [15:0]       ad_size_i = '0;
  logic [15:0]       di_size_i = '0;
  logic              busy_o, done_o, op_valid_o, perm_start_o;
  op_e               op_o;
  logic [3:0]        perm_rounds_o;
  logic              perm_done_i;
  logic              blk_valid_o;
  logic              blk_ready_i = 1'b1;
  logic              blk_sel_o, blk_last_o;
  logic [PAD_AW-1:0] blk_pad_idx_o;
  sched_state_e      state_o;
  logic              auto_done = 1'b0;
  logic              manual_done = 1'b0;
  logic              auto_en = 1'b1;
  logic              abort_now;
`ifdef ASCON_SCHED_ABORT_EN
  logic              abort_i = 1'b0;
  assign abort_now = abort_i;
`else
  assign abort_now = 1'b0;
`endif

  assign perm_done_i = auto_done | manual_done;

  int perm_lat = 1;
  int pend = 0;
  int done_cnt = 0;
  int errors = 0;
  int checks = 0;

  logic [5:0] exp_blk_q[$];
  logic [5:0] obs_blk_q[$];
  logic [3:0] exp_rnd_q[$];
  logic [3:0] obs_rnd_q[$];

  ascon_aead_sequencer #(.SIZE_WIDTH(16), .BLOCK_AW(12)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .ad_size_i    (ad_size_i),
    .di_size_i    (di_size_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .op_valid_o   (op_valid_o),
    .op_o         (op_o),
    .perm_start_o (perm_start_o),
    .perm_rounds_o(perm_rounds_o),
    .perm_done_i  (perm_done_i),
    .blk_valid_o  (blk_valid_o),
    .blk_ready_i  (blk_ready_i),
    .blk_sel_o    (blk_sel_o),
    .blk_last_o   (blk_last_o),
    .blk_pad_idx_o(blk_pad_idx_o),
`ifdef ASCON_SCHED_ABORT_EN
    .abort_i      (abort_i),
`endif
    .state_o      (state_o)
  );

  // clock / reset
  initial forever #5 clk_i = ~clk_i;

  // permutation responder: done pulse L cycles after perm_start_o
  initial forever begin
    @(negedge clk_i);
    auto_done = 1'b0;
    if (!rst_ni || abort_now) pend = 0;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) auto_done = 1'b1;
    end
    if (perm_start_o && auto_en && rst_ni) pend = perm_lat;
  end

  // monitor: records what the DUT produced
  initial forever begin
    @(negedge clk_i);
    if (blk_valid_o && blk_ready_i) obs_blk_q.push_back({blk_sel_o, blk_last_o, blk_pad_idx_o});
    if (perm_start_o) obs_rnd_q.push_back(perm_rounds_o);
    if (done_o) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_expected(input int ad, input int di);
    int nad, ndi;
    nad = (ad == 0) ? 0 : ad / 16 + 1;
    ndi = di / 16 + 1;
    for (int i = 0; i < nad; i++)
      exp_blk_q.push_back({1'b0, (i == nad - 1), (i == nad - 1) ? 4'(ad % 16) : 4'd0});
    for (int i = 0; i < ndi; i++)
      exp_blk_q.push_back({1'b1, (i == ndi - 1), (i == ndi - 1) ? 4'(di % 16) : 4'd0});
    exp_rnd_q.push_back(4'd12);
    for (int i = 0; i < nad + ndi - 1; i++) exp_rnd_q.push_back(4'd8);
    exp_rnd_q.push_back(4'd12);
  endtask

  function automatic int exp_cycles(input int ad, input int di, input int l);
    int nad, ndi;
    nad = (ad == 0) ? 0 : ad / 16 + 1;
    ndi = di / 16 + 1;
    return 8 + 2 * l + (nad + ndi - 1) * (l + 2);
  endfunction

  // driver: start a sequence and count cycles after the start edge until done_o
  task automatic run_seq(input int ad, input int di, input int l, input int limit,
                         output int ncyc, output bit to);
    obs_blk_q.delete();
    obs_rnd_q.delete();
    done_cnt    = 0;
    perm_lat    = l;
    blk_ready_i = 1'b1;
    ad_size_i   = 16'(ad);
    di_size_i   = 16'(di);
    start_i     = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    ncyc = 0;
    to   = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk_i);
      if (done_o) begin
        ncyc = n;
        to   = 1'b0;
        break;
      end
    end
    if (to) begin
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_o, ST_IDLE); end
    checks++; if ({busy_o, done_o, op_valid_o, perm_start_o, blk_valid_o} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {busy_o, done_o, op_valid_o, perm_start_o, blk_valid_o}); end
    checks++; if (op_o !== OP_INIT_LOAD) begin errors++; $display("FAIL reset_op: got %0d want 0", op_o); end
    checks++; if ({perm_rounds_o, blk_sel_o, blk_last_o, blk_pad_idx_o} !== 10'b0) begin errors++; $display("FAIL reset_side: got %h want 0", {perm_rounds_o, blk_sel_o, blk_last_o, blk_pad_idx_o}); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_sequences();
    int tab_ad[9], tab_di[9], tab_l[9];
    int n, exp_n;
    bit to;
    logic [5:0] eb, ob;
    logic [3:0] er, orr;
    tab_ad = '{0, 16, 16, 5, 31, 0, 0, 0, 0};
    tab_di = '{0, 35, 35, 0, 17, 0, 0, 0, 0};
    tab_l  = '{1, 1, 3, 2, 1, 1, 1, 1, 1};
    for (int i = 5; i < 9; i++) begin
      tab_ad[i] = $urandom_range(0, 80);
      tab_di[i] = $urandom_range(0, 80);
      tab_l[i]  = $urandom_range(1, 4);
    end
    for (int i = 0; i < 9; i++) begin
      push_expected(tab_ad[i], tab_di[i]);
      exp_n = exp_cycles(tab_ad[i], tab_di[i], tab_l[i]);
      run_seq(tab_ad[i], tab_di[i], tab_l[i], 2000, n, to);
      checks++; if (to) begin errors++; $display("FAIL seq%0d_timeout: done_o never seen, want cycle %0d", i, exp_n); end
      checks++; if (n != exp_n) begin errors++; $display("FAIL seq%0d_latency: got %0d want %0d", i, n, exp_n); end
      checks++; if (obs_blk_q.size() != exp_blk_q.size()) begin errors++; $display("FAIL seq%0d_blk_count: got %0d want %0d", i, obs_blk_q.size(), exp_blk_q.size()); end
      while (exp_blk_q.size() > 0 && obs_blk_q.size() > 0) begin
        eb = exp_blk_q.pop_front();
        ob = obs_blk_q.pop_front();
        checks++; if (ob !== eb) begin errors++; $display("FAIL seq%0d_blk {sel,last,pad}: got %h want %h", i, ob, eb); end
      end
      checks++; if (obs_rnd_q.size() != exp_rnd_q.size()) begin errors++; $display("FAIL seq%0d_perm_count: got %0d want %0d", i, obs_rnd_q.size(), exp_rnd_q.size()); end
      while (exp_rnd_q.size() > 0 && obs_rnd_q.size() > 0) begin
        er  = exp_rnd_q.pop_front();
        orr = obs_rnd_q.pop_front();
        checks++; if (orr !== er) begin errors++; $display("FAIL seq%0d_rounds: got %0d want %0d", i, orr, er); end
      end
      exp_blk_q.delete();
      exp_rnd_q.delete();
      tick();
      checks++; if (state_o !== ST_IDLE || done_o !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL seq%0d_end: state %0d done %b pulses %0d want 0 0 1", i, state_o, done_o, done_cnt); end
    end
  endtask

  task automatic test_backpressure();
    int ad_xfers;
    bit seen;
    obs_blk_q.delete();
    done_cnt    = 0;
    perm_lat    = 1;
    blk_ready_i = 1'b0;
    ad_size_i   = 16'd5;
    di_size_i   = 16'd0;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk_i);
      if (state_o == ST_AD_BLK) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_reach_ad_blk: state %0d want %0d", state_o, ST_AD_BLK); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk_i);
      checks++; if ({blk_valid_o, blk_sel_o, blk_last_o, blk_pad_idx_o} !== 7'b1_0_1_0101) begin errors++; $display("FAIL bp_hold%0d: got %b want 1010101", k, {blk_valid_o, blk_sel_o, blk_last_o, blk_pad_idx_o}); end
    end
    @(posedge clk_i);
    #1;
    blk_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++; if (state_o !== ST_AD_PERM || perm_start_o !== 1'b1 || perm_rounds_o !== 4'd8) begin errors++; $display("FAIL bp_ad_perm: state %0d start %b rounds %0d want %0d 1 8", state_o, perm_start_o, perm_rounds_o, ST_AD_PERM); end
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_done: done_o not seen within 50 cycles"); end
    ad_xfers = 0;
    foreach (obs_blk_q[j]) if (obs_blk_q[j][5] == 1'b0) ad_xfers++;
    checks++; if (ad_xfers != 1) begin errors++; $display("FAIL bp_ad_xfers: got %0d want 1", ad_xfers); end
    tick();
  endtask

  task automatic test_spurious_done();
    auto_en = 1'b0;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL sp_idle: got %0d want %0d", state_o, ST_IDLE); end
    ad_size_i = 16'd0;
    di_size_i = 16'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    checks++; if (state_o !== ST_INIT_PERM || perm_start_o !== 1'b1) begin errors++; $display("FAIL sp_init_first: state %0d start %b want %0d 1", state_o, perm_start_o, ST_INIT_PERM); end
    manual_done = 1'b1;
    tick();
    checks++; if (state_o !== ST_INIT_PERM || perm_start_o !== 1'b0) begin errors++; $display("FAIL sp_first_cycle_ignored: state %0d start %b want %0d 0", state_o, perm_start_o, ST_INIT_PERM); end
    tick();
    manual_done = 1'b0;
    checks++; if (state_o !== ST_KEY_TAIL || op_valid_o !== 1'b1 || op_o !== OP_KEY_TAIL) begin errors++; $display("FAIL sp_key_tail: state %0d op %0d want %0d %0d", state_o, op_o, ST_KEY_TAIL, OP_KEY_TAIL); end
    blk_ready_i = 1'b0;
    tick();
    manual_done = 1'b1;
    tick();
    tick();
    manual_done = 1'b0;
    checks++; if (state_o !== ST_DI_BLK) begin errors++; $display("FAIL sp_di_blk_hold: got %0d want %0d", state_o, ST_DI_BLK); end
    blk_ready_i = 1'b1;
    tick();
    checks++; if (state_o !== ST_KEY_FINAL || op_o !== OP_KEY_FINAL) begin errors++; $display("FAIL sp_key_final: state %0d op %0d want %0d %0d", state_o, op_o, ST_KEY_FINAL, OP_KEY_FINAL); end
    tick();
    manual_done = 1'b1;
    tick();
    checks++; if (state_o !== ST_FINAL_PERM) begin errors++; $display("FAIL sp_final_first: got %0d want %0d", state_o, ST_FINAL_PERM); end
    tick();
    manual_done = 1'b0;
    checks++; if (state_o !== ST_TAG || done_o !== 1'b1 || op_o !== OP_TAG_OUT) begin errors++; $display("FAIL sp_tag: state %0d done %b want %0d 1", state_o, done_o, ST_TAG); end
    tick();
    auto_en = 1'b1;
  endtask

  task automatic test_start_busy();
    int n, ad_x, di_x;
    bit seen;
    obs_blk_q.delete();
    obs_rnd_q.delete();
    perm_lat  = 1;
    ad_size_i = 16'd0;
    di_size_i = 16'd0;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    start_i   = 1'b1;
    ad_size_i = 16'd32;
    seen = 1'b0;
    n = 1;
    for (int k = 2; k < 60 && !seen; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        n = k;
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    checks++; if (!seen || n != 10) begin errors++; $display("FAIL busy_latency: got %0d want 10", n); end
    ad_x = 0;
    di_x = 0;
    foreach (obs_blk_q[j]) if (obs_blk_q[j][5]) di_x++; else ad_x++;
    checks++; if (ad_x != 0 || di_x != 1) begin errors++; $display("FAIL busy_blocks: ad %0d di %0d want 0 1", ad_x, di_x); end
    checks++; if (obs_rnd_q.size() != 2) begin errors++; $display("FAIL busy_perms: got %0d want 2", obs_rnd_q.size()); end
    tick();
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL busy_end: got %0d want %0d", state_o, ST_IDLE); end
    ad_size_i = 16'd0;
  endtask

  task automatic test_mid_reset();
    bit seen;
    perm_lat  = 2;
    ad_size_i = 16'd0;
    di_size_i = 16'd48;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk_i);
      if (state_o == ST_DI_PERM) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_reach_di: state %0d want %0d", state_o, ST_DI_PERM); end
    rst_ni = 1'b0;
    tick();
    checks++; if (state_o !== ST_IDLE || {busy_o, done_o, op_valid_o, perm_start_o, blk_valid_o} !== 5'b0) begin errors++; $display("FAIL rst_mid: state %0d strobes %b want 0 00000", state_o, {busy_o, done_o, op_valid_o, perm_start_o, blk_valid_o}); end
    rst_ni = 1'b1;
    done_cnt = 0;
    repeat (20) tick();
    checks++; if (done_cnt != 0 || state_o !== ST_IDLE) begin errors++; $display("FAIL rst_no_done: pulses %0d state %0d want 0 0", done_cnt, state_o); end
  endtask

`ifdef ASCON_SCHED_ABORT_EN
  task automatic test_abort();
    int n;
    bit seen, to;
    perm_lat  = 3;
    ad_size_i = 16'd20;
    di_size_i = 16'd0;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk_i);
      if (state_o == ST_AD_PERM) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL abort_reach: state %0d want %0d", state_o, ST_AD_PERM); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++; if (state_o !== ST_IDLE || busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle: state %0d busy %b want 0 0", state_o, busy_o); end
    done_cnt = 0;
    repeat (10) tick();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    run_seq(20, 0, 1, 200, n, to);
    checks++; if (to || n != exp_cycles(20, 0, 1)) begin errors++; $display("FAIL abort_rerun: got %0d want %0d", n, exp_cycles(20, 0, 1)); end
    checks++; if (obs_blk_q.size() != 3) begin errors++; $display("FAIL abort_rerun_blocks: got %0d want 3", obs_blk_q.size()); end
    tick();
  endtask
`endif

  task automatic test_max_count();
    int n;
    bit to;
    run_seq(16'hFFFF, 16'hFFF0, 1, 40000, n, to);
    checks++; if (to || n != 24583) begin errors++; $display("FAIL max_latency: got %0d want 24583", n); end
    checks++; if (obs_blk_q.size() != 8192) begin errors++; $display("FAIL max_blk_count: got %0d want 8192", obs_blk_q.size()); end
    checks++; if (obs_rnd_q.size() != 8193) begin errors++; $display("FAIL max_perm_count: got %0d want 8193", obs_rnd_q.size()); end
    if (obs_blk_q.size() == 8192) begin
      checks++; if (obs_blk_q[4094] !== 6'h00) begin errors++; $display("FAIL max_ad_penult: got %h want 00", obs_blk_q[4094]); end
      checks++; if (obs_blk_q[4095] !== 6'h1F) begin errors++; $display("FAIL max_ad_last: got %h want 1f", obs_blk_q[4095]); end
      checks++; if (obs_blk_q[4096] !== 6'h20) begin errors++; $display("FAIL max_di_first: got %h want 20", obs_blk_q[4096]); end
      checks++; if (obs_blk_q[8191] !== 6'h30) begin errors++; $display("FAIL max_di_last: got %h want 30", obs_blk_q[8191]); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_backpressure();
    test_spurious_done();
    test_start_busy();
    test_mid_reset();
`ifdef ASCON_SCHED_ABORT_EN
    test_abort();
`endif
    test_max_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascon_aead_sequencer.md
# ascon_aead_sequencer

Control FSM for the Ascon-AEAD128 core. It latches the associated-data (AD) and data-in (DI) byte sizes and splits them into block counts and pad indices. It then sequences the datapath through initialisation, AD absorption, domain separation, DI processing, finalisation and tag output, issuing permutation starts and block handshakes. It sits between the register/DMA front end and the state/permutation datapath.

## Interface
- SIZE_WIDTH, 16, width of the AD/DI byte-size inputs.
- BLOCK_AW, 12, width of the full-block counters; `SIZE_WIDTH >= PAD_AW + BLOCK_AW` is required.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  start request, sampled only in IDLE.
- ad_size_i  in  SIZE_WIDTH  AD length in bytes.
- di_size_i  in  SIZE_WIDTH  plaintext/ciphertext length in bytes.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse in TAG.
- op_valid_o  out  1  one-cycle single-cycle datapath operation strobe.
- op_o  out  op_e  INIT_LOAD, KEY_TAIL, DOMSEP, KEY_FINAL or TAG_OUT.
- perm_start_o  out  1  one-cycle permutation start.
- perm_rounds_o  out  4  round count, valid with perm_start_o: 12 (init/final) or 8.
- perm_done_i  in  1  permutation-complete pulse.
- blk_valid_o  out  1  block transfer request.
- blk_ready_i  in  1  datapath has absorbed the block (and emitted output for DI).
- blk_sel_o  out  1  0 = AD, 1 = DI.
- blk_last_o  out  1  the current block is the final padded block.
- blk_pad_idx_o  out  PAD_AW  byte position of the 0x01 pad; meaningful only when blk_last_o is high.

## Operation
- **Start.** In IDLE, start_i latches the sizes and moves the FSM to LOAD.
  - Counters are loaded with `ad_cnt = ad_size[PAD_AW+:BLOCK_AW]` and `di_cnt = di_size[PAD_AW+:BLOCK_AW]`.
  - Pad indices are loaded with `size[PAD_AW-1:0]`.
  - `ad_en = (ad_size != 0)`.
- **States and transitions:**
  - IDLE → LOAD (op INIT_LOAD).
  - LOAD → INIT_PERM (12 rounds).
  - INIT_PERM → KEY_TAIL on perm_done_i.
  - KEY_TAIL → AD_BLK if ad_en, else DOMSEP.
  - AD_BLK → AD_PERM (8 rounds) on transfer.
  - AD_PERM → DOMSEP on perm_done_i if the block was last; otherwise back to AD_BLK.
  - DOMSEP → DI_BLK.
  - DI_BLK → KEY_FINAL on a last-block transfer; otherwise → DI_PERM (8 rounds).
  - DI_PERM → DI_BLK on perm_done_i.
  - KEY_FINAL → FINAL_PERM (12 rounds).
  - FINAL_PERM → TAG on perm_done_i.
  - TAG (op TAG_OUT, done_o) → IDLE.
- **Block handshake.**
  - `blk_last_o = (cnt == 0)` for the selected stream. The counter decrements on each non-last transfer.
  - A transfer occurs when `blk_valid_o && blk_ready_i`.
  - blk_sel_o, blk_last_o and blk_pad_idx_o are held stable while blk_valid_o is high.
- **Block counts.**
  - AD issues `ad_cnt + 1` blocks when ad_en, otherwise 0. A size that is a nonzero multiple of 16 gives a final block with pad index 0.
  - DI always issues `di_cnt + 1` blocks. The last DI block is not permuted.
- **Permutation handshake.**
  - perm_start_o is asserted only in the first cycle of each *_PERM state.
  - perm_done_i is honoured only from the second cycle of a *_PERM state onward and is ignored in all other states.
- start_i is ignored while busy_o is high.
- A counter value of all-ones in BLOCK_AW bits must sequence correctly, with no wrap before the last block.

## Timing
- **Reset.** State IDLE. All outputs are 0; op_o = INIT_LOAD encoding 0. Counters and latched sizes are 0.
- **Latency.** With perm_done_i L ≥ 1 cycles after perm_start_o, blk_ready_i tied high, and ad=0, di=0:
  - start_i is sampled at edge 0.
  - done_o is asserted in cycle 8+2L.
- **Op cycles.** Each op cycle lasts exactly one cycle. The datapath applies the op at the closing edge, and the next state may start a permutation in the following cycle.
- **Mid-sequence reset.** rst_ni low in any state returns the FSM to IDLE at the next edge. No done_o is produced.

## Configuration
- ASCON_SCHED_ABORT_EN defined: adds input `abort_i`.
  - When abort_i is high, the next state is IDLE in any state. Outputs deassert in the following cycle, and no done_o is produced.
  - abort_i has priority over start_i and perm_done_i.
- ASCON_SCHED_ABORT_EN undefined: no abort_i port. A sequence ends only via TAG or reset.

## Structure
- **ascon_pack** holds:
  - PAD_AW (4);
  - `op_e` enum (INIT_LOAD=0, KEY_TAIL, DOMSEP, KEY_FINAL, TAG_OUT);
  - `sched_state_e` enum;
  - constants ROUNDS_A=12 and ROUNDS_B=8.
- **Sub-module.** ascon_size_decoder is instantiated on the latched sizes to produce the block counts and pad indices.
- **Top level.** The FSM, the two counters and the first-cycle flag live in the top module.

## Test plan
- ad=0, di=0, L=1, ready high → done_o at cycle 10. Zero AD blocks, one DI block with last=1 and pad=0, two perm_start_o pulses (12, 12).
- ad=16, di=35 → AD blocks (last 0), (last 1, pad 0). DI blocks last=0, 0, then 1 with pad 3. Six perm starts with rounds 12, 8, 8, 8, 8, 12.
- ad=5, di=0, blk_ready_i low for 4 cycles → blk_valid_o and the sideband signals stay stable. Exactly one transfer occurs, then AD_PERM.
- perm_done_i pulsed outside *_PERM states and in the first PERM cycle → ignored, no state change.
- start_i while busy → ignored. rst_ni low mid-DI → IDLE next edge, outputs 0, no done_o.
- ASCON_SCHED_ABORT_EN: abort_i in AD_PERM → IDLE next edge, no done_o. The following start_i runs a full sequence normally.
